// File: rtl/cmpunit_iter.sv
// rtl/cmpunit_iter.sv - multi-cycle chunked RISC-V branch comparator (optional CMPUNIT_EARLY_EXIT_EN)
module cmpunit_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [2:0]       cmp_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_EQ  = 3'd0;
    localparam logic [2:0] OP_NE  = 3'd1;
    localparam logic [2:0] OP_LT  = 3'd2;
    localparam logic [2:0] OP_GE  = 3'd3;
    localparam logic [2:0] OP_LTU = 3'd4;
    localparam logic [2:0] OP_GEU = 3'd5;

    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [IDX_W-1:0] idx;
    logic             diff;
    logic             lt;

    logic             flip;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_ne;
    logic             chunk_lt;
    logic             run_exit;
    logic             res_next;

    assign in_ready = (state == S_IDLE) && !rst;
    assign busy     = (state != S_IDLE);

    // Signed compares become unsigned by flipping the sign bit of both operands
    always_comb begin
        flip = (cmp_op == OP_LT) || (cmp_op == OP_GE);
        a_in = operand_a ^ (flip ? MSB_MASK : '0);
        b_in = operand_b ^ (flip ? MSB_MASK : '0);
    end

    // Select the chunk addressed by idx and compare it
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        chunk_ne = (a_chunk != b_chunk);
        chunk_lt = (a_chunk < b_chunk);
    end

    // Decide whether this RUN cycle is the last one
    always_comb begin
`ifdef CMPUNIT_EARLY_EXIT_EN
        run_exit = (idx == '0) || (!diff && chunk_ne);
`else
        run_exit = (idx == '0);
`endif
    end

    // Map the accumulated diff/lt flags onto the requested condition
    always_comb begin
        res_next = 1'b0;
        case (op_q)
            OP_EQ:          res_next = !diff;
            OP_NE:          res_next = diff;
            OP_LT, OP_LTU:  res_next = lt;
            OP_GE, OP_GEU:  res_next = !lt;
            default:        res_next = 1'b0;
        endcase
    end

    // Control FSM and datapath registers; first chunk difference decides ordering
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            idx       <= '0;
            diff      <= 1'b0;
            lt        <= 1'b0;
            out_valid <= 1'b0;
            result    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        op_q  <= cmp_op;
                        idx   <= IDX_W'(NCHUNK - 1);
                        diff  <= 1'b0;
                        lt    <= 1'b0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!diff && chunk_ne) begin
                        diff <= 1'b1;
                        lt   <= chunk_lt;
                    end
                    if (run_exit) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        result    <= res_next;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmpunit_iter.sv
// tb/tb_cmpunit_iter.sv - table-driven and random self-checking bench for cmpunit_iter
module tb_cmpunit_iter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid0, in_valid1;
    logic [31:0] opa, opb;
    logic [2:0]  op;
    logic        out_ready;
    logic        in_ready0, out_valid0, result0, busy0;
    logic        in_ready1, out_valid1, result1, busy1;
    logic        sel;

    cmpunit_iter #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .operand_a(opa), .operand_b(opb), .cmp_op(op),
        .out_valid(out_valid0), .out_ready(out_ready), .result(result0), .busy(busy0)
    );

    cmpunit_iter #(.WIDTH(32), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .operand_a(opa), .operand_b(opb), .cmp_op(op),
        .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .busy(busy1)
    );

    logic in_ready_m, out_valid_m, result_m, busy_m;
    assign in_ready_m  = sel ? in_ready1  : in_ready0;
    assign out_valid_m = sel ? out_valid1 : out_valid0;
    assign result_m    = sel ? result1    : result0;
    assign busy_m      = sel ? busy1      : busy0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        exp;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ref_result(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
        case (o)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) <  $signed(b);
            3'd3:    return $signed(a) >= $signed(b);
            3'd4:    return a <  b;
            3'd5:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Cycles from accept edge to out_valid: one per chunk examined plus one
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input int cw);
        int n;
        n = 32 / cw;
`ifdef CMPUNIT_EARLY_EXIT_EN
        for (int k = 1; k <= n; k++) begin
            if ((a >> (32 - k*cw)) != (b >> (32 - k*cw))) return k + 1;
        end
`endif
        return n + 1;
    endfunction

    task automatic set_valid(input logic v);
        if (sel) in_valid1 = v; else in_valid0 = v;
    endtask

    // Issue one request at a negedge, measure latency, stall, then consume it
    task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                           input int stall, input string tag, output logic res, output int lat);
        int n;
        res = 1'b0;
        lat = -1;
        n = 0;
        while (!in_ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready"}, in_ready_m, 1);
        opa = a; opb = b; op = o; out_ready = 1'b0;
        set_valid(1'b1);
        @(negedge clk);
        set_valid(1'b0);
        opa = $urandom; opb = $urandom; op = 3'($urandom_range(0, 7));
        n = 0;
        while (!out_valid_m && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " out_valid"}, out_valid_m, 1);
        if (out_valid_m) lat = n;
        res = result_m;
        for (int i = 0; i < stall; i++) begin
            if (i == 1) begin
                opa = $urandom; opb = $urandom; op = 3'($urandom_range(0, 7));
                set_valid(1'b1);
            end
            @(negedge clk);
            set_valid(1'b0);
            check({tag, " stall valid"}, out_valid_m, 1);
            check({tag, " stall result"}, result_m, res);
            check({tag, " stall in_ready"}, in_ready_m, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " drained valid"}, out_valid_m, 0);
        check({tag, " drained busy"}, busy_m, 0);
    endtask

    initial begin
        logic  r;
        int    lat;
        logic [31:0] ra, rb;
        logic [2:0]  ro;

        vt[0]  = '{32'h12345678, 32'h12345678, 3'd0, 1'b1};
        vt[1]  = '{32'h12345678, 32'h12345678, 3'd1, 1'b0};
        vt[2]  = '{32'h80000000, 32'h7FFFFFFF, 3'd2, 1'b1};
        vt[3]  = '{32'h80000000, 32'h7FFFFFFF, 3'd4, 1'b0};
        vt[4]  = '{32'h80000000, 32'h7FFFFFFF, 3'd3, 1'b0};
        vt[5]  = '{32'h80000000, 32'h7FFFFFFF, 3'd5, 1'b1};
        vt[6]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 3'd2, 1'b1};
        vt[7]  = '{32'h00000001, 32'h00000002, 3'd6, 1'b0};
        vt[8]  = '{32'h00000001, 32'h00000001, 3'd7, 1'b0};
        vt[9]  = '{32'h00000001, 32'h00000002, 3'd4, 1'b1};
        vt[10] = '{32'h00010000, 32'h00000000, 3'd3, 1'b1};
        vt[11] = '{32'hFFFFFF00, 32'h000000FF, 3'd2, 1'b1};

        sel = 1'b0;
        rst = 1'b1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        opa = '0; opb = '0; op = '0; out_ready = 1'b0;

        // Reset held two cycles
        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid0, 0);
        check("reset result", result0, 0);
        check("reset busy", busy0, 0);
        check("reset in_ready", in_ready0, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post reset in_ready", in_ready0, 1);

        // Fixed-latency corner with constant expectation
        run_req(32'h12345678, 32'h12345678, 3'd0, 0, "eq lat", r, lat);
        check("eq lat result", r, 1);
        check("eq lat cycles", lat, 5);

        run_req(32'h80000000, 32'h7FFFFFFF, 3'd2, 0, "msb lat", r, lat);
`ifdef CMPUNIT_EARLY_EXIT_EN
        check("msb lat cycles", lat, 2);
`else
        check("msb lat cycles", lat, 5);
`endif

        // Back-pressure with ignored in_valid pulse
        run_req(32'h80000000, 32'h7FFFFFFF, 3'd5, 10, "stall", r, lat);
        check("stall result", r, 1);

        // Table vectors
        foreach (vt[i]) begin
            run_req(vt[i].a, vt[i].b, vt[i].op, i % 3, $sformatf("vec%0d", i), r, lat);
            check($sformatf("vec%0d result", i), r, vt[i].exp);
            check($sformatf("vec%0d latency", i), lat, ref_lat(vt[i].a, vt[i].b, 8));
        end

        // Single-bit chunk instance
        sel = 1'b1;
        run_req(32'hFFFFFFFE, 32'hFFFFFFFF, 3'd2, 0, "chunk1", r, lat);
        check("chunk1 result", r, 1);
        check("chunk1 latency", lat, 33);
        sel = 1'b0;

        // Reset in the middle of RUN (idx==2)
        opa = 32'hA5A5A5A5; opb = 32'hA5A5A5A5; op = 3'd0;
        in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        @(negedge clk);
        check("midrst busy before", busy0, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst out_valid", out_valid0, 0);
        check("midrst busy", busy0, 0);
        check("midrst result", result0, 0);
        rst = 1'b0;
        #1;
        check("midrst in_ready", in_ready0, 1);
        @(negedge clk);
        run_req(32'h1, 32'h2, 3'd4, 0, "after rst", r, lat);
        check("after rst result", r, 1);

        // Random requests against the reference model
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = ra;
                2: rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = {~ra[31], ra[30:0]};
            endcase
            ro = 3'($urandom_range(0, 7));
            run_req(ra, rb, ro, $urandom_range(0, 3), $sformatf("rnd%0d", i), r, lat);
            check($sformatf("rnd%0d result", i), r, ref_result(ra, rb, ro));
            check($sformatf("rnd%0d latency", i), lat, ref_lat(ra, rb, 8));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
